uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OverSample, default 8, meaning oversample ticks per bit (even, >= 4).
REQ-002 SHALL have parameter DataBits, default 8, meaning data bits per frame.
REQ-003 SHALL have port i_clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_baud_clk  input  1  oversample clock from baud generator, same i_clk domain; each 0->1 transition is one tick.
REQ-006 SHALL have port i_rx  input  1  serial line, asynchronous, idle high.
REQ-007 SHALL have port o_data  output  DataBits  received byte, valid while o_valid=1.
REQ-008 SHALL have port o_valid  output  1  received byte available.
REQ-009 SHALL have port i_ready  input  1  consumer accepts o_data when o_valid&&i_ready.
REQ-010 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port o_overrun  output  1  sticky: byte dropped because o_valid was still pending.

Function
REQ-013 SHALL pass i_rx through a 2-flop synchronizer (rx_s), both flops resetting to 1.
REQ-014 SHALL register i_baud_clk once and generate tick = i_baud_clk & ~prev, one i_clk wide; all FSM/counter activity advances only on tick.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP; tick counter cnt and bit index idx.
REQ-016 IDLE: on tick with rx_s=0 -> START, cnt=0.
REQ-017 START: cnt increments per tick; on the tick with cnt==OverSample/2-1, rx_s=0 -> DATA (cnt=0, idx=0), rx_s=1 -> IDLE (false start, no outputs change).
REQ-018 DATA: cnt increments per tick; on the tick with cnt==OverSample-1, shift rx_s in LSB-first, cnt=0, idx++; after bit DataBits-1 -> STOP.
REQ-019 STOP: on the tick with cnt==OverSample-1 sample rx_s and -> IDLE; no further tick needed before the next start is accepted.
REQ-020 Stop=1: byte complete; stop=0: o_frame_err pulses for exactly one i_clk, byte discarded, o_valid/o_data unchanged.
REQ-021 Byte complete with o_valid=0: o_data<=byte, o_valid<=1 on the next i_clk edge.
REQ-022 o_valid&&i_ready with no completion same cycle: o_valid<=0; o_data holds its value.
REQ-023 Completion while o_valid=1 and i_ready=1 same cycle: new byte loaded, o_valid stays 1, no overrun.
REQ-024 Completion while o_valid=1 and i_ready=0: new byte dropped, o_data keeps old byte, o_overrun<=1 and stays 1 until reset.
REQ-025 Counter widths SHALL be $clog2(OverSample) and $clog2(DataBits+1); no wrap occurs within legal operation.
REQ-026 o_busy SHALL equal (state!=IDLE) combinationally from the state register.

Reset
REQ-027 While i_rst_n=0: state=IDLE, cnt=0, idx=0, shift reg=0, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, synchronizer=1, tick-edge register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; after release the block waits in IDLE for a fresh start bit, and the partial byte is never presented.

Verification
REQ-029 Nominal: OverSample=8, tick every 4 i_clk, send 0xA5 with stop=1, i_ready=0 -> o_data=0xA5, o_valid=1 held, o_frame_err=0, o_overrun=0.
REQ-030 Frame error: send 0x3C with stop=0 -> o_frame_err high exactly 1 cycle, o_valid stays 0, next frame 0x5A received correctly.
REQ-031 Glitch: i_rx low for 2 ticks then high -> FSM returns to IDLE from START, o_busy drops, o_valid stays 0.
REQ-032 Overrun: send 0x11 then 0x22, i_ready=0 -> o_data=0x11, o_valid=1, o_overrun=1; then i_ready=1 one cycle -> o_valid=0.
REQ-033 Simultaneous: 0x11 pending, i_ready=1 exactly on 0x22 completion cycle -> o_data=0x22, o_valid=1, o_overrun=0.
REQ-034 Reset mid-frame: assert i_rst_n=0 during DATA bit 3 of 0xFF -> all outputs 0 immediately; after release, send 0x81 -> o_data=0x81, no spurious byte.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation at mid-bit, LSB-first data,
// stop-bit check, and a one-entry valid/ready output register with overrun flag.
module uart_rx #(
    parameter int OverSample = 8,
    parameter int DataBits   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_baud_clk,
    input  logic                i_rx,
    output logic [DataBits-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_frame_err,
    output logic                o_overrun
);

    localparam int CntW = $clog2(OverSample);
    localparam int IdxW = $clog2(DataBits + 1);

    localparam logic [CntW-1:0] CntHalf = CntW'(OverSample / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OverSample - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CntW-1:0]     r_cnt;
    logic [CntW-1:0]     w_cnt_next;
    logic [IdxW-1:0]     r_idx;
    logic [IdxW-1:0]     w_idx_next;
    logic [DataBits-1:0] r_shift;
    logic [DataBits-1:0] w_shift_next;
    logic [DataBits:0]   w_shift_cat;

    logic                r_rx_meta;
    logic                r_rx_s;
    logic                r_baud_prev;
    logic                w_tick;
    logic                w_done;
    logic                w_ferr;

    logic [DataBits-1:0] r_data;
    logic                r_valid;
    logic                r_frame_err;
    logic                r_overrun;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_baud_prev <= 1'b0;
        end else begin
            r_rx_meta   <= i_rx;
            r_rx_s      <= r_rx_meta;
            r_baud_prev <= i_baud_clk;
        end
    end

    assign w_tick = i_baud_clk & ~r_baud_prev;

    // New sample enters at the MSB so the first bit received ends up at bit 0.
    assign w_shift_cat = {r_rx_s, r_shift};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_done       = 1'b0;
        w_ferr       = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        w_state_next = START;
                        w_cnt_next   = '0;
                    end
                end
                START: begin
                    if (r_cnt == CntHalf) begin
                        w_cnt_next = '0;
                        if (!r_rx_s) begin
                            w_state_next = DATA;
                            w_idx_next   = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == CntLast) begin
                        w_shift_next = w_shift_cat[DataBits:1];
                        w_cnt_next   = '0;
                        w_idx_next   = r_idx + 1'b1;
                        if (r_idx == IdxLast) begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == CntLast) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                        w_done       = r_rx_s;
                        w_ferr       = ~r_rx_s;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
        end
    end

    // A completing byte may replace a pending one only if it is consumed this same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            if (w_done) begin
                if (!r_valid || i_ready) begin
                    r_data  <= w_shift_next;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != IDLE);

endmodule
